// File: rtl/instr_block_mem_pkg.sv
// Package: instr_block_mem_pkg
// Shared definitions for the block instruction memory and the instruction
// cache that sits in front of it.
//   state_t      - two-state read FSM encoding (IDLE / BUSY)
//   offset_bits  - number of byte-offset bits inside one aligned block
package instr_block_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Byte-offset bits within a block of block_words words of word_w bits each.
  function automatic int offset_bits(input int block_words, input int word_w);
    return $clog2(block_words * word_w / 8);
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Module: instr_mem_array
// Byte-addressed RAM with one synchronous byte write port and one
// combinational block-wide read port.
//   clk         - clock, rising edge
//   load_en     - byte write enable
//   load_addr   - byte write address (already reduced modulo depth)
//   load_data   - byte write data
//   block_addr  - block-aligned byte address of the block to read
//   block_data  - block contents, byte k of the block at bits [k*8 +: 8]
// A write landing in the block being read is forwarded to block_data in the
// same cycle, so a register capturing block_data on that edge sees the new
// byte (write-first).
module instr_mem_array #(
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int DEPTH_BYTES = 1024
) (
  input  logic                             clk,
  input  logic                             load_en,
  input  logic [$clog2(DEPTH_BYTES)-1:0]   load_addr,
  input  logic [7:0]                       load_data,
  input  logic [$clog2(DEPTH_BYTES)-1:0]   block_addr,
  output logic [BLOCK_WORDS*WORD_W-1:0]    block_data
);

  localparam int ADDR_W      = $clog2(DEPTH_BYTES);
  localparam int BLOCK_BYTES = BLOCK_WORDS * WORD_W / 8;

  // Contents are deliberately never cleared: reset does not touch program memory.
  logic [7:0] mem_reg [DEPTH_BYTES];

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_reg[load_addr] <= load_data;
    end
  end

  generate
    for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_byte
      logic [ADDR_W-1:0] byte_idx;
      // block_addr is block-aligned, so adding the lane index never carries
      // out of the block.
      assign byte_idx = block_addr + ADDR_W'(gi);
      assign block_data[gi*8 +: 8] = (load_en && (load_addr == byte_idx)) ?
                                     load_data : mem_reg[byte_idx];
    end
  endgenerate

endmodule

// File: rtl/instr_block_mem.sv
// Module: instr_block_mem
// Instruction memory returning a whole aligned block after a fixed latency,
// with a BUSYWAIT handshake and a synchronous byte-load port for preloading.
//   CLK        - clock, rising edge
//   RESET      - synchronous, active-high; aborts any pending read
//   READ       - block read request
//   ADDRESS    - byte address; block-offset bits ignored, wraps modulo depth
//   BUSYWAIT   - high while a read is pending or being accepted
//   READDATA   - block; word i at bits [i*WORD_W +: WORD_W], little-endian
//   LOAD_EN    - byte write enable (active in any state, even under RESET)
//   LOAD_ADDR  - byte write address, wraps modulo depth
//   LOAD_DATA  - byte write data
module instr_block_mem
  import instr_block_mem_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 5
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          READ,
  input  logic [31:0]                   ADDRESS,
  output logic                          BUSYWAIT,
  output logic [BLOCK_WORDS*WORD_W-1:0] READDATA,
  input  logic                          LOAD_EN,
  input  logic [31:0]                   LOAD_ADDR,
  input  logic [7:0]                    LOAD_DATA
);

  localparam int ADDR_W      = $clog2(DEPTH_BYTES);
  localparam int OFFSET_BITS = offset_bits(BLOCK_WORDS, WORD_W);
  localparam int CNT_W       = $clog2(LATENCY + 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << OFFSET_BITS) - 1);

  state_t                          state_reg;
  logic [CNT_W-1:0]                cnt_reg;
  logic [ADDR_W-1:0]               addr_reg;
  logic [BLOCK_WORDS*WORD_W-1:0]   readdata_reg;
  logic [BLOCK_WORDS*WORD_W-1:0]   block_data;
  logic [ADDR_W-1:0]               aligned_addr;

  // Upper address bits beyond the memory size are dropped (wrap-around).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ADDRESS[31:ADDR_W], LOAD_ADDR[31:ADDR_W]};

  assign aligned_addr = ADDRESS[ADDR_W-1:0] & ALIGN_MASK;

  instr_mem_array #(
    .WORD_W      (WORD_W),
    .BLOCK_WORDS (BLOCK_WORDS),
    .DEPTH_BYTES (DEPTH_BYTES)
  ) u_array (
    .clk        (CLK),
    .load_en    (LOAD_EN),
    .load_addr  (LOAD_ADDR[ADDR_W-1:0]),
    .load_data  (LOAD_DATA),
    .block_addr (addr_reg),
    .block_data (block_data)
  );

  // The counter is loaded with LATENCY-1 on acceptance and the block is
  // captured on the edge after it reaches zero, giving LATENCY edges total.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      addr_reg     <= '0;
      readdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (READ) begin
            addr_reg  <= aligned_addr;
            cnt_reg   <= CNT_W'(LATENCY - 1);
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end else begin
            readdata_reg <= block_data;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // In IDLE the request itself raises BUSYWAIT so the requester stalls in
  // the same cycle it asks.
  assign BUSYWAIT = (state_reg == BUSY) | READ;
  assign READDATA = readdata_reg;

endmodule

// File: tb/tb_instr_block_mem.sv
module tb_instr_block_mem;

  localparam int LAT   = 5;
  localparam int DEPTH = 1024;
  localparam int BB    = 16;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         READ;
  logic [31:0]  ADDRESS;
  logic         BUSYWAIT;
  logic [127:0] READDATA;
  logic         LOAD_EN;
  logic [31:0]  LOAD_ADDR;
  logic [7:0]   LOAD_DATA;

  always #5 CLK = ~CLK;

  instr_block_mem #(
    .WORD_W      (32),
    .BLOCK_WORDS (4),
    .DEPTH_BYTES (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .READ      (READ),
    .ADDRESS   (ADDRESS),
    .BUSYWAIT  (BUSYWAIT),
    .READDATA  (READDATA),
    .LOAD_EN   (LOAD_EN),
    .LOAD_ADDR (LOAD_ADDR),
    .LOAD_DATA (LOAD_DATA)
  );

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] exp_data;
  } vec_t;

  vec_t         tbl [4];
  logic [7:0]   model_mem [DEPTH];
  int           n_vec = 0;
  int           n_err = 0;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Reference: the block containing byte address a, memory wrapping at DEPTH.
  function automatic logic [127:0] model_block(input logic [31:0] a);
    logic [127:0] r;
    int base;
    base = (int'(a % DEPTH) / BB) * BB;
    for (int i = 0; i < BB; i++) r[i*8 +: 8] = model_mem[base + i];
    return r;
  endfunction

  task automatic load_byte(input logic [31:0] a, input logic [7:0] d);
    LOAD_EN   = 1'b1;
    LOAD_ADDR = a;
    LOAD_DATA = d;
    model_mem[a % DEPTH] = d;
    tick;
    LOAD_EN = 1'b0;
  endtask

  // One read transaction; disturb toggles READ and moves ADDRESS while busy,
  // rnd_loads writes random bytes on edges up to completion, hit_byte1 writes
  // 0xAA to byte 1 on the completion edge.
  task automatic do_read(input string name, input logic [31:0] addr, input bit disturb,
                         input bit rnd_loads, input bit hit_byte1, output logic [127:0] got);
    int edges;
    logic [127:0] prev;
    prev    = READDATA;
    READ    = 1'b1;
    ADDRESS = addr;
    #1;
    check({name, " busywait_on_request"}, {127'b0, BUSYWAIT}, 128'd1);
    tick;
    edges = 0;
    for (int k = 1; k <= LAT + 3; k++) begin
      if (disturb && k < LAT) begin
        READ    = 1'($urandom_range(0, 1));
        ADDRESS = 32'h40;
      end else begin
        READ = 1'b0;
      end
      LOAD_EN = 1'b0;
      if (rnd_loads && k <= LAT && $urandom_range(0, 1) == 1) begin
        LOAD_EN   = 1'b1;
        LOAD_ADDR = 32'($urandom_range(0, 2*DEPTH - 1));
        LOAD_DATA = 8'($urandom);
        model_mem[LOAD_ADDR % DEPTH] = LOAD_DATA;
      end
      if (hit_byte1 && k == LAT) begin
        LOAD_EN   = 1'b1;
        LOAD_ADDR = 32'h1;
        LOAD_DATA = 8'hAA;
        model_mem[1] = 8'hAA;
      end
      tick;
      edges = k;
      if (k == LAT - 1) check({name, " hold_while_busy"}, READDATA, prev);
      if (!BUSYWAIT) break;
    end
    LOAD_EN = 1'b0;
    READ    = 1'b0;
    check({name, " latency"}, 128'(edges), 128'(LAT));
    got = READDATA;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] got;
    logic [31:0]  a;
    logic [127:0] blk0, blk1;
    blk0 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    blk1 = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
    tbl[0] = '{32'h0000_0005, blk0};
    tbl[1] = '{32'h0000_0410, blk1};
    tbl[2] = '{32'h0000_001C, blk1};
    tbl[3] = '{32'h0000_080B, blk0};

    RESET = 1'b1; READ = 1'b0; ADDRESS = '0;
    LOAD_EN = 1'b0; LOAD_ADDR = '0; LOAD_DATA = '0;
    tick; tick;
    RESET = 1'b0;
    check("reset readdata", READDATA, 128'd0);
    check("reset busywait", {127'b0, BUSYWAIT}, 128'd0);

    // Preload everything so no read ever sees uninitialised storage.
    for (int i = 0; i < DEPTH; i++) load_byte(32'(i), 8'($urandom));
    for (int i = 0; i < 32; i++) load_byte(32'(i), 8'(i));

    for (int v = 0; v < 4; v++) begin
      do_read($sformatf("table[%0d]", v), tbl[v].addr, 1'b0, 1'b0, 1'b0, got);
      check($sformatf("table[%0d] data", v), got, tbl[v].exp_data);
    end

    // Ignored READ/ADDRESS changes while busy.
    do_read("disturbed", 32'h5, 1'b1, 1'b0, 1'b0, got);
    check("disturbed data", got, blk0);
    repeat (3) tick;
    check("idle hold", READDATA, blk0);

    // Reset in the middle of a read.
    READ = 1'b1; ADDRESS = 32'h10;
    tick;
    READ = 1'b0;
    tick; tick;
    RESET = 1'b1;
    tick;
    RESET = 1'b0;
    check("abort readdata", READDATA, 128'd0);
    check("abort busywait", {127'b0, BUSYWAIT}, 128'd0);
    repeat (LAT + 2) tick;
    check("abort no late data", READDATA, 128'd0);

    // Load coincident with reset is still performed.
    RESET = 1'b1; LOAD_EN = 1'b1; LOAD_ADDR = 32'h2; LOAD_DATA = 8'h77;
    model_mem[2] = 8'h77;
    tick;
    RESET = 1'b0; LOAD_EN = 1'b0;
    do_read("load_in_reset", 32'h0, 1'b0, 1'b0, 1'b0, got);
    check("load_in_reset byte2", {120'b0, got[23:16]}, 128'h77);

    // Write-first on the completion edge.
    do_read("write_first", 32'h0, 1'b0, 1'b0, 1'b1, got);
    check("write_first data", got, model_block(32'h0));
    check("write_first byte1", {120'b0, got[15:8]}, 128'hAA);

    // Back-to-back: READ held high across completion starts another read.
    READ = 1'b1; ADDRESS = 32'h20;
    tick;
    ADDRESS = 32'h30;
    repeat (LAT) tick;
    check("b2b first data", READDATA, model_block(32'h20));
    check("b2b busywait held", {127'b0, BUSYWAIT}, 128'd1);
    tick;
    READ = 1'b0;
    repeat (LAT - 1) tick;
    check("b2b second busy", {127'b0, BUSYWAIT}, 128'd1);
    tick;
    check("b2b second done", {127'b0, BUSYWAIT}, 128'd0);
    check("b2b second data", READDATA, model_block(32'h30));

    // Random reads with random concurrent loads.
    for (int r = 0; r < 40; r++) begin
      a = $urandom;
      do_read($sformatf("rand[%0d]", r), a, 1'($urandom_range(0, 1)), 1'b1, 1'b0, got);
      check($sformatf("rand[%0d] data @%h", r, a), got, model_block(a));
      repeat ($urandom_range(0, 2)) tick;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
